ng_emem_responder: RTL
======================

// Module: ng_emem_responder
// PURPOSE
// Memory-side responder for erasable-memory (E-MEM) requests issued by the CPU memory buffer.
// Accepts one read or write request at a time and generates the parity bit on writes.
// Checks odd parity on reads, returns the 15-bit word plus an error flag, and counts parity failures.
// Sits between the G-register/buffer logic and a single-port synchronous RAM.
// PARAMETERS
// ADDR_W   10  E-MEM word address width (1024 words, octal 0000-1777)
// RD_LAT   1   RAM read latency in CLK2 cycles (1..3)
// CNT_W    8   width of saturating parity-error counter
// PORTS
// CLK2       in   1       system clock, all state on rising edge
// GENRST     in   1       asynchronous, active-low reset
// REQ_VALID  in   1       request present
// REQ_READY  out  1       responder can accept (high only in IDLE)
// REQ_WR     in   1       1=write, 0=read
// REQ_ADDR   in   ADDR_W  word address
// REQ_DATA   in   15      write data: bit14=sign(G16), 13:0 magnitude
// RSP_VALID  out  1       response present, held until RSP_READY
// RSP_READY  in   1       initiator consumes response
// RSP_DATA   out  15      read data (read) / echo of written data (write)
// RSP_PERR   out  1       read word failed odd-parity check (0 for writes)
// RAM_ADDR   out  ADDR_W  registered RAM address
// RAM_WDATA  out  16      {parity, data[14:0]}, registered
// RAM_WREN   out  1       registered write strobe, one cycle per write
// RAM_RDATA  in   16      {parity, data[14:0]} from RAM
// CLR_ERR    in   1       synchronous clear of ERR_CNT
// ERR_CNT    out  CNT_W   saturating count of read parity failures
// BEHAVIOUR
// - Reset (GENRST=0, async): state=IDLE; REQ_READY=1 after release; RSP_VALID=0; RSP_PERR=0;
//   RSP_DATA=0; RAM_ADDR=0; RAM_WDATA=0; RAM_WREN=0; ERR_CNT=0. A request in flight is dropped, no response.
// - Parity: stored bit15 = ~^data[14:0], so each 16-bit word has an odd number of ones.
//   Read check: PERR = ~(^RAM_RDATA[15:0]).
// - FSM: IDLE -> (accept, WR) -> WRITE -> RESP; IDLE -> (accept, RD) -> RD_WAIT -> RD_CHK -> RESP;
//   RESP -> IDLE when RSP_READY=1.
// - Accept when REQ_VALID & REQ_READY on edge T. Latch addr/data/wr at T.
//   RAM_ADDR and RAM_WDATA are valid from T+1 until the next accept.
// - WRITE: RAM_WREN=1 for exactly cycle T+1. RSP_VALID rises at T+2 with RSP_DATA=written data, RSP_PERR=0.
// - READ: RD_WAIT lasts RD_LAT cycles. RD_CHK samples RAM_RDATA. RSP_VALID rises at T+RD_LAT+2.
//   On parity failure RSP_DATA still returns RAM_RDATA[14:0] unmodified.
// - RSP_VALID/RSP_DATA/RSP_PERR are stable while RSP_READY=0. RSP_READY with RSP_VALID=0 is ignored.
// - Back-to-back: REQ_READY is 1 again the cycle after the response handshake, so minimum spacing
//   between accepts is 3 (write) or RD_LAT+3 (read) cycles.
// - ERR_CNT increments by 1 in the RD_CHK cycle on failure and saturates at 2^CNT_W-1.
//   If CLR_ERR and a failure occur in the same cycle, ERR_CNT becomes 1. CLR_ERR alone sets it to 0.
// - Address is never range-checked; the decoder upstream guarantees addr <= octal 1777.
// STRUCTURE
// - Shared package/header: FSM state encodings (IDLE, WRITE, RD_WAIT, RD_CHK, RESP) and the parity
//   function odd_par(data15).
// - One sub-module, ng_par_gen_chk: combinational 15-bit parity generate plus 16-bit check.
//   The FSM, counters and output registers stay in this module.
// TESTING
// - Reset mid-read: assert GENRST=0 in RD_WAIT -> RSP_VALID=0, RAM_WREN=0 immediately, REQ_READY=1 after release.
// - Write addr 0o0017, data 15'o00000 -> RAM_WREN one cycle, RAM_WDATA=16'h8000, RSP_VALID at T+2, PERR=0.
// - Write 0o0017=15'o00001 then read 0o0017 -> RAM_WDATA=16'h0001, read RSP_DATA=15'o00001, PERR=0,
//   RSP_VALID at T+RD_LAT+2.
// - Read with RAM_RDATA forced to 16'h0000 -> RSP_PERR=1, RSP_DATA=0, ERR_CNT 0->1.
//   Same cycle with CLR_ERR=1 and ERR_CNT=5 -> ERR_CNT=1.
// - Hold RSP_READY=0 for 10 cycles with REQ_VALID=1 -> REQ_READY=0 and response stable throughout.
//   Release -> next request accepted the following cycle.
// - Force 300 parity failures with CNT_W=8 -> ERR_CNT saturates at 255, then CLR_ERR -> 0.

Source files
------------

// File: rtl/ng_emem_responder_pkg.sv
// rtl/ng_emem_responder_pkg.sv - shared FSM encoding and odd-parity helper for the E-MEM responder
package ng_emem_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_CHK  = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Parity bit that makes {par, data} carry an odd number of ones.
  function automatic logic odd_par(input logic [14:0] data15);
    return ~(^data15);
  endfunction

endpackage

// File: rtl/ng_emem_responder_par_gen_chk.sv
// rtl/ng_emem_responder_par_gen_chk.sv - odd-parity generate for writes and check for read words
module ng_par_gen_chk
  import ng_emem_responder_pkg::*;
(
  input  logic [14:0] data,
  input  logic [15:0] word,
  output logic        par,
  output logic        perr
);

  assign par  = odd_par(data);
  assign perr = ~(^word);

endmodule

// File: rtl/ng_emem_responder.sv
// rtl/ng_emem_responder.sv - E-MEM request/response engine between the CPU buffer and a sync RAM
module ng_emem_responder
  import ng_emem_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              CLK2,
  input  logic              GENRST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WR,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [14:0]       REQ_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [14:0]       RSP_DATA,
  output logic              RSP_PERR,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [15:0]       RAM_WDATA,
  output logic              RAM_WREN,
  input  logic [15:0]       RAM_RDATA,
  input  logic              CLR_ERR,
  output logic [CNT_W-1:0]  ERR_CNT
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state, state_nxt;
  logic [1:0]  wait_cnt;
  logic        accept;
  logic        par_bit;
  logic        rd_perr;

  assign REQ_READY = (state == ST_IDLE);
  assign accept    = REQ_VALID & REQ_READY;

  ng_par_gen_chk u_par (
    .data (REQ_DATA),
    .word (RAM_RDATA),
    .par  (par_bit),
    .perr (rd_perr)
  );

  always_ff @(posedge CLK2 or negedge GENRST) begin
    if (!GENRST) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (REQ_VALID) state_nxt = REQ_WR ? ST_WRITE : ST_RD_WAIT;
      ST_WRITE:   state_nxt = ST_RESP;
      ST_RD_WAIT: if (wait_cnt == 2'd0) state_nxt = ST_RD_CHK;
      ST_RD_CHK:  state_nxt = ST_RESP;
      ST_RESP:    if (RSP_READY) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // RAM side is registered at accept; the write strobe lives for exactly one cycle.
  always_ff @(posedge CLK2 or negedge GENRST) begin
    if (!GENRST) begin
      RAM_ADDR  <= '0;
      RAM_WDATA <= '0;
      RAM_WREN  <= 1'b0;
      wait_cnt  <= 2'd0;
    end else begin
      RAM_WREN <= accept & REQ_WR;
      if (accept) begin
        RAM_ADDR  <= REQ_ADDR;
        RAM_WDATA <= {par_bit, REQ_DATA};
        wait_cnt  <= 2'(RD_LAT - 1);
      end else if (state == ST_RD_WAIT && wait_cnt != 2'd0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge CLK2 or negedge GENRST) begin
    if (!GENRST) begin
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_PERR  <= 1'b0;
    end else begin
      case (state)
        ST_WRITE: begin
          RSP_VALID <= 1'b1;
          RSP_DATA  <= RAM_WDATA[14:0];
          RSP_PERR  <= 1'b0;
        end
        ST_RD_CHK: begin
          RSP_VALID <= 1'b1;
          RSP_DATA  <= RAM_RDATA[14:0];
          RSP_PERR  <= rd_perr;
        end
        ST_RESP: if (RSP_READY) RSP_VALID <= 1'b0;
        default: ;
      endcase
    end
  end

  // A failure coinciding with a clear counts as the first error after the clear.
  always_ff @(posedge CLK2 or negedge GENRST) begin
    if (!GENRST) begin
      ERR_CNT <= '0;
    end else if (state == ST_RD_CHK && rd_perr) begin
      if (CLR_ERR)                 ERR_CNT <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (ERR_CNT != CNT_MAX) ERR_CNT <= ERR_CNT + 1'b1;
    end else if (CLR_ERR) begin
      ERR_CNT <= '0;
    end
  end

endmodule
